// File: rtl/layer_pkg.sv
// Shared types and constants for the fully-connected layer sequencer.
package layer_pkg;

    // Sequencer states, one per bus phase of a neuron
    typedef enum logic [3:0] {
        IDLE,
        CHK,
        W_WADDR,
        W_AADDR,
        W_NIN,
        W_GO,
        R_RES,
        R_BIAS,
        WT_BIAS,
        W_OUT,
        NEXT
    } layer_state_t;

    // CPU-visible register indices
    localparam logic [3:0] REG_START = 4'd0;
    localparam logic [3:0] REG_BIAS  = 4'd1;
    localparam logic [3:0] REG_W     = 4'd2;
    localparam logic [3:0] REG_A     = 4'd3;
    localparam logic [3:0] REG_OUT   = 4'd4;
    localparam logic [3:0] REG_NIN   = 4'd5;
    localparam logic [3:0] REG_NOUT  = 4'd6;
    localparam logic [3:0] REG_RELU  = 4'd7;

    // dotopt register indices
    localparam logic [3:0] DOT_REG_GO = 4'd0;
    localparam logic [3:0] DOT_REG_W  = 4'd2;
    localparam logic [3:0] DOT_REG_A  = 4'd3;
    localparam logic [3:0] DOT_REG_N  = 4'd5;

    // Working copy of the run configuration, frozen at start.
    // The weight base is not kept here: the row pointer is seeded from it.
    typedef struct packed {
        logic [31:0] bias_base;
        logic [31:0] a_base;
        logic [31:0] out_base;
        logic [31:0] n_in;
        logic        relu_en;
    } layer_cfg_t;

    // Optional ReLU on a Q16.16 value
    function automatic logic [31:0] relu_clamp(input logic [31:0] v, input logic en);
        return (en && v[31]) ? '0 : v;
    endfunction

endpackage

// File: rtl/layer_regs.sv
// CPU register file for layer_sched: programming registers, start
// detection, snapshot of the working configuration and readback mux.
module layer_regs
    import layer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       slave_address,
    input  logic             slave_read,
    input  logic             slave_write,
    input  logic [31:0]      slave_writedata,
    output logic             slave_waitrequest,
    output logic [31:0]      slave_readdata,
    input  logic             busy_i,
    input  logic [CNT_W-1:0] done_cnt_i,
    output logic             start_o,
    output logic [31:0]      w_base_o,
    output logic [CNT_W-1:0] n_out_o,
    output layer_cfg_t       cfg_o
);

    logic [31:0]      bias_base_q;
    logic [31:0]      w_base_q;
    logic [31:0]      a_base_q;
    logic [31:0]      out_base_q;
    logic [31:0]      n_in_q;
    logic [31:0]      n_out_q;
    logic             relu_q;
    layer_cfg_t       cfg_q;
    logic [CNT_W-1:0] n_out_run_q;

    assign start_o  = slave_write && (slave_address == REG_START) && !busy_i;
    // Only a status read of index 0 can stall, and only while a run is active
    assign slave_waitrequest = slave_read && (slave_address == REG_START) && busy_i;
    assign w_base_o = w_base_q;
    assign n_out_o  = n_out_run_q;
    assign cfg_o    = cfg_q;

    // CPU writes to the programming registers; indices 0 and 8-15 store nothing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_base_q <= '0;
            w_base_q    <= '0;
            a_base_q    <= '0;
            out_base_q  <= '0;
            n_in_q      <= '0;
            n_out_q     <= '0;
            relu_q      <= 1'b0;
        end else if (slave_write) begin
            case (slave_address)
                REG_BIAS: bias_base_q <= slave_writedata;
                REG_W:    w_base_q    <= slave_writedata;
                REG_A:    a_base_q    <= slave_writedata;
                REG_OUT:  out_base_q  <= slave_writedata;
                REG_NIN:  n_in_q      <= slave_writedata;
                REG_NOUT: n_out_q     <= slave_writedata;
                REG_RELU: relu_q      <= slave_writedata[0];
                default:  ;
            endcase
        end
    end

    // Freeze the configuration at start so mid-run writes only affect the next run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q       <= '0;
            n_out_run_q <= '0;
        end else if (start_o) begin
            cfg_q.bias_base <= bias_base_q;
            cfg_q.a_base    <= a_base_q;
            cfg_q.out_base  <= out_base_q;
            cfg_q.n_in      <= n_in_q;
            cfg_q.relu_en   <= relu_q;
            n_out_run_q     <= n_out_q[CNT_W-1:0];
        end
    end

    // Readback mux; unmapped indices read as zero
    always_comb begin
        slave_readdata = '0;
        case (slave_address)
            REG_START: slave_readdata = 32'(done_cnt_i);
            REG_BIAS:  slave_readdata = bias_base_q;
            REG_W:     slave_readdata = w_base_q;
            REG_A:     slave_readdata = a_base_q;
            REG_OUT:   slave_readdata = out_base_q;
            REG_NIN:   slave_readdata = n_in_q;
            REG_NOUT:  slave_readdata = n_out_q;
            REG_RELU:  slave_readdata = {31'b0, relu_q};
            default:   ;
        endcase
    end

endmodule

// File: rtl/layer_sched.sv
// Fully-connected layer sequencer: per output neuron, programs dotopt,
// waits for the dot product, adds the bias from SDRAM with optional ReLU
// and writes the activation to SRAM.
module layer_sched
    import layer_pkg::*;
#(
    parameter int unsigned AW            = 32,
    parameter int unsigned MAX_NOUT_LOG2 = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic          slave_waitrequest,
    input  logic [3:0]    slave_address,
    input  logic          slave_read,
    output logic [31:0]   slave_readdata,
    input  logic          slave_write,
    input  logic [31:0]   slave_writedata,
    input  logic          dot_waitrequest,
    output logic [3:0]    dot_address,
    output logic          dot_read,
    input  logic [31:0]   dot_readdata,
    output logic          dot_write,
    output logic [31:0]   dot_writedata,
    input  logic          bias_waitrequest,
    output logic [AW-1:0] bias_address,
    output logic          bias_read,
    input  logic [31:0]   bias_readdata,
    input  logic          bias_readdatavalid,
    input  logic          out_waitrequest,
    output logic [AW-1:0] out_address,
    output logic          out_write,
    output logic [31:0]   out_writedata
);

    layer_state_t             state_q;
    logic [MAX_NOUT_LOG2-1:0] j_q;
    logic [MAX_NOUT_LOG2-1:0] done_cnt_q;
    logic [AW-1:0]            w_row_q;
    logic [31:0]              acc_q;

    logic                     dot_write_q;
    logic                     dot_read_q;
    logic [3:0]               dot_address_q;
    logic [31:0]              dot_writedata_q;
    logic                     bias_read_q;
    logic [AW-1:0]            bias_address_q;
    logic                     out_write_q;
    logic [AW-1:0]            out_address_q;
    logic [31:0]              out_writedata_q;

    logic                     start;
    logic [31:0]              w_base_live;
    logic [MAX_NOUT_LOG2-1:0] n_out_run;
    layer_cfg_t               cfg;

    logic [AW-1:0]            j_x4;
    logic [AW-1:0]            n_in_x4;
    logic [AW-1:0]            bias_addr_j;
    logic [AW-1:0]            out_addr_j;
    logic [31:0]              bias_sum;

    layer_regs #(
        .CNT_W(MAX_NOUT_LOG2)
    ) u_regs (
        .clk               (clk),
        .rst               (rst),
        .slave_address     (slave_address),
        .slave_read        (slave_read),
        .slave_write       (slave_write),
        .slave_writedata   (slave_writedata),
        .slave_waitrequest (slave_waitrequest),
        .slave_readdata    (slave_readdata),
        .busy_i            (state_q != IDLE),
        .done_cnt_i        (done_cnt_q),
        .start_o           (start),
        .w_base_o          (w_base_live),
        .n_out_o           (n_out_run),
        .cfg_o             (cfg)
    );

    assign dot_write     = dot_write_q;
    assign dot_read      = dot_read_q;
    assign dot_address   = dot_address_q;
    assign dot_writedata = dot_writedata_q;
    assign bias_read     = bias_read_q;
    assign bias_address  = bias_address_q;
    assign out_write     = out_write_q;
    assign out_address   = out_address_q;
    assign out_writedata = out_writedata_q;

    // Per-neuron addresses and the bias accumulation, all wrapping
    always_comb begin
        j_x4        = AW'({j_q, 2'b00});
        n_in_x4     = AW'({cfg.n_in, 2'b00});
        bias_addr_j = AW'(cfg.bias_base) + j_x4;
        out_addr_j  = AW'(cfg.out_base) + j_x4;
        bias_sum    = acc_q + bias_readdata;
    end

    // Sequencer with registered bus outputs; each strobe is raised on entry
    // to its state and dropped on acceptance, so at most one is ever active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            j_q             <= '0;
            done_cnt_q      <= '0;
            w_row_q         <= '0;
            acc_q           <= '0;
            dot_write_q     <= 1'b0;
            dot_read_q      <= 1'b0;
            dot_address_q   <= '0;
            dot_writedata_q <= '0;
            bias_read_q     <= 1'b0;
            bias_address_q  <= '0;
            out_write_q     <= 1'b0;
            out_address_q   <= '0;
            out_writedata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= CHK;
                        j_q        <= '0;
                        done_cnt_q <= '0;
                        w_row_q    <= AW'(w_base_live);
                    end
                end
                CHK: begin
                    if (j_q >= n_out_run) begin
                        state_q <= IDLE;
                    end else begin
                        state_q         <= W_WADDR;
                        dot_write_q     <= 1'b1;
                        dot_address_q   <= DOT_REG_W;
                        dot_writedata_q <= 32'(w_row_q);
                    end
                end
                W_WADDR: begin
                    if (!dot_waitrequest) begin
                        state_q         <= W_AADDR;
                        dot_address_q   <= DOT_REG_A;
                        dot_writedata_q <= cfg.a_base;
                    end
                end
                W_AADDR: begin
                    if (!dot_waitrequest) begin
                        state_q         <= W_NIN;
                        dot_address_q   <= DOT_REG_N;
                        dot_writedata_q <= cfg.n_in;
                    end
                end
                W_NIN: begin
                    if (!dot_waitrequest) begin
                        state_q         <= W_GO;
                        dot_address_q   <= DOT_REG_GO;
                        dot_writedata_q <= '0;
                    end
                end
                W_GO: begin
                    if (!dot_waitrequest) begin
                        state_q         <= R_RES;
                        dot_write_q     <= 1'b0;
                        dot_read_q      <= 1'b1;
                        dot_address_q   <= DOT_REG_GO;
                        dot_writedata_q <= '0;
                    end
                end
                R_RES: begin
                    if (!dot_waitrequest) begin
                        state_q        <= R_BIAS;
                        acc_q          <= dot_readdata;
                        dot_read_q     <= 1'b0;
                        bias_read_q    <= 1'b1;
                        bias_address_q <= bias_addr_j;
                    end
                end
                R_BIAS: begin
                    if (!bias_waitrequest) begin
                        bias_read_q <= 1'b0;
                        // zero-latency data arriving with acceptance skips the wait state
                        if (bias_readdatavalid) begin
                            state_q         <= W_OUT;
                            acc_q           <= bias_sum;
                            out_write_q     <= 1'b1;
                            out_address_q   <= out_addr_j;
                            out_writedata_q <= relu_clamp(bias_sum, cfg.relu_en);
                        end else begin
                            state_q <= WT_BIAS;
                        end
                    end
                end
                WT_BIAS: begin
                    if (bias_readdatavalid) begin
                        state_q         <= W_OUT;
                        acc_q           <= bias_sum;
                        out_write_q     <= 1'b1;
                        out_address_q   <= out_addr_j;
                        out_writedata_q <= relu_clamp(bias_sum, cfg.relu_en);
                    end
                end
                W_OUT: begin
                    if (!out_waitrequest) begin
                        state_q     <= NEXT;
                        out_write_q <= 1'b0;
                    end
                end
                NEXT: begin
                    state_q    <= CHK;
                    j_q        <= j_q + 1'b1;
                    done_cnt_q <= done_cnt_q + 1'b1;
                    w_row_q    <= w_row_q + n_in_x4;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
